// File: rtl/axil_apb_pkg.sv
// Shared definitions for the AXI-Lite to APB bridge: FSM states and AXI response codes.
package axil_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_apb_if.sv
// AXI-Lite bundle (aw, w, b, ar, r channels) with Slave and Master views.
interface AXI_LITE #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   aw_addr;
   logic [2:0]      aw_prot;
   logic            aw_valid;
   logic            aw_ready;
   logic [DW-1:0]   w_data;
   logic [DW/8-1:0] w_strb;
   logic            w_valid;
   logic            w_ready;
   logic [1:0]      b_resp;
   logic            b_valid;
   logic            b_ready;
   logic [AW-1:0]   ar_addr;
   logic [2:0]      ar_prot;
   logic            ar_valid;
   logic            ar_ready;
   logic [DW-1:0]   r_data;
   logic [1:0]      r_resp;
   logic            r_valid;
   logic            r_ready;

   modport Slave (
      input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_prot, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );

   modport Master (
      output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_prot, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );
endinterface

// File: rtl/axil_apb_bridge.sv
// AXI-Lite slave to APB master, one transaction in flight; >=3 cycles accept-to-response (1 for DECERR),
// response held until b_ready/r_ready. Optional ACCESS timeout under `AXIL_APB_TIMEOUT_EN.
module axil_apb_bridge
   import axil_apb_pkg::*;
#(
   parameter int          AXI_LITE_AW    = 32,
   parameter int          AXI_LITE_DW    = 32,
   parameter int          APB_AW         = 32,
   parameter logic [31:0] PERIPH_BA      = 32'h0000_0000,
   parameter logic [31:0] PERIPH_SIZE    = 32'h0001_0000,
   parameter int          TIMEOUT_CYCLES = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   AXI_LITE.Slave            axil_slave,
   output logic [APB_AW-1:0] paddr_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [31:0]       pwdata_o,
   output logic [3:0]        pstrb_o,
   output logic [2:0]        pprot_o,
   input  logic [31:0]       prdata_i,
   input  logic              pready_i,
   input  logic              pslverr_i
);

   if (AXI_LITE_DW != 32) begin : g_dw_chk
      $error("axil_apb_bridge: only 32-bit AXI-Lite data is supported");
   end
   if (APB_AW > AXI_LITE_AW) begin : g_aw_chk
      $error("axil_apb_bridge: APB_AW must not exceed AXI_LITE_AW");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_to_chk
      $error("axil_apb_bridge: TIMEOUT_CYCLES must be at least 1");
   end

   localparam logic [AXI_LITE_AW-1:0] BASE = AXI_LITE_AW'(PERIPH_BA);
   localparam logic [AXI_LITE_AW-1:0] SIZE = AXI_LITE_AW'(PERIPH_SIZE);

   state_e            state_q, state_d;
   logic              aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, ar_ready_q, ar_ready_d;
   logic              b_valid_q, b_valid_d, r_valid_q, r_valid_d;
   logic [1:0]        resp_q, resp_d;
   logic [31:0]       r_data_q, r_data_d;
   logic [APB_AW-1:0] paddr_q, paddr_d;
   logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
   logic [31:0]       pwdata_q, pwdata_d;
   logic [3:0]        pstrb_q, pstrb_d;
   logic [2:0]        pprot_q, pprot_d;
   logic              last_wr_q, last_wr_d;

`ifdef AXIL_APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   logic [AXI_LITE_AW-1:0] wr_off, rd_off;
   logic                   wr_hit, rd_hit, wr_req, rd_req;

   // An address below BASE wraps to a large offset, so one compare covers both window edges.
   assign wr_off = axil_slave.aw_addr - BASE;
   assign rd_off = axil_slave.ar_addr - BASE;
   assign wr_hit = (wr_off < SIZE);
   assign rd_hit = (rd_off < SIZE);
   assign wr_req = axil_slave.aw_valid && axil_slave.w_valid;
   assign rd_req = axil_slave.ar_valid;

   always_comb begin
      state_d    = state_q;
      aw_ready_d = 1'b0;
      w_ready_d  = 1'b0;
      ar_ready_d = 1'b0;
      b_valid_d  = b_valid_q;
      r_valid_d  = r_valid_q;
      resp_d     = resp_q;
      r_data_d   = r_data_q;
      paddr_d    = paddr_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      pstrb_d    = pstrb_q;
      pprot_d    = pprot_q;
      last_wr_d  = last_wr_q;
`ifdef AXIL_APB_TIMEOUT_EN
      cnt_d      = '0;
`endif
      unique case (state_q)
         IDLE: begin
            // A ready pulsed last cycle means the handshake completes on this edge.
            if (aw_ready_q) begin
               paddr_d  = wr_off[APB_AW-1:0];
               pwrite_d = 1'b1;
               pwdata_d = axil_slave.w_data;
               pstrb_d  = axil_slave.w_strb;
               pprot_d  = axil_slave.aw_prot;
               if (wr_hit) begin
                  state_d = SETUP;
                  psel_d  = 1'b1;
               end else begin
                  state_d   = RESP;
                  b_valid_d = 1'b1;
                  resp_d    = RESP_DECERR;
               end
            end else if (ar_ready_q) begin
               paddr_d  = rd_off[APB_AW-1:0];
               pwrite_d = 1'b0;
               pwdata_d = '0;
               pstrb_d  = '0;
               pprot_d  = axil_slave.ar_prot;
               if (rd_hit) begin
                  state_d = SETUP;
                  psel_d  = 1'b1;
               end else begin
                  state_d   = RESP;
                  r_valid_d = 1'b1;
                  resp_d    = RESP_DECERR;
                  r_data_d  = '0;
               end
            end else if (wr_req && (!last_wr_q || !rd_req)) begin
               aw_ready_d = 1'b1;
               w_ready_d  = 1'b1;
               last_wr_d  = 1'b1;
            end else if (rd_req) begin
               ar_ready_d = 1'b1;
               last_wr_d  = 1'b0;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (pready_i) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               resp_d    = pslverr_i ? RESP_SLVERR : RESP_OKAY;
               if (pwrite_q) begin
                  b_valid_d = 1'b1;
               end else begin
                  r_valid_d = 1'b1;
                  r_data_d  = prdata_i;
               end
            end
`ifdef AXIL_APB_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d   = RESP;
               psel_d    = 1'b0;
               penable_d = 1'b0;
               resp_d    = RESP_SLVERR;
               if (pwrite_q) begin
                  b_valid_d = 1'b1;
               end else begin
                  r_valid_d = 1'b1;
                  r_data_d  = '0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`else
            // A slave that never raises pready stalls the bridge until reset.
`endif
         end
         RESP: begin
            if ((b_valid_q && axil_slave.b_ready) || (r_valid_q && axil_slave.r_ready)) begin
               state_d   = IDLE;
               b_valid_d = 1'b0;
               r_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         ar_ready_q <= 1'b0;
         b_valid_q  <= 1'b0;
         r_valid_q  <= 1'b0;
         resp_q     <= '0;
         r_data_q   <= '0;
         paddr_q    <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         pstrb_q    <= '0;
         pprot_q    <= '0;
         last_wr_q  <= 1'b0;
`ifdef AXIL_APB_TIMEOUT_EN
         cnt_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         aw_ready_q <= aw_ready_d;
         w_ready_q  <= w_ready_d;
         ar_ready_q <= ar_ready_d;
         b_valid_q  <= b_valid_d;
         r_valid_q  <= r_valid_d;
         resp_q     <= resp_d;
         r_data_q   <= r_data_d;
         paddr_q    <= paddr_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         pstrb_q    <= pstrb_d;
         pprot_q    <= pprot_d;
         last_wr_q  <= last_wr_d;
`ifdef AXIL_APB_TIMEOUT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end

   assign axil_slave.aw_ready = aw_ready_q;
   assign axil_slave.w_ready  = w_ready_q;
   assign axil_slave.ar_ready = ar_ready_q;
   assign axil_slave.b_valid  = b_valid_q;
   assign axil_slave.b_resp   = resp_q;
   assign axil_slave.r_valid  = r_valid_q;
   assign axil_slave.r_resp   = resp_q;
   assign axil_slave.r_data   = r_data_q;

   assign paddr_o   = paddr_q;
   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign pwrite_o  = pwrite_q;
   assign pwdata_o  = pwdata_q;
   assign pstrb_o   = pstrb_q;
   assign pprot_o   = pprot_q;

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Scoreboard bench for axil_apb_bridge: stimulus pushes expected APB transfers and AXI responses,
// negedge monitors pop and compare them as the DUT presents them.
module tb_axil_apb_bridge;
   import axil_apb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] paddr, pwdata, prdata;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;

   AXI_LITE #(.AW(32), .DW(32)) axil ();

   axil_apb_bridge #(.TIMEOUT_CYCLES(8)) dut (
      .clk_i(clk), .rst_i(rst), .axil_slave(axil),
      .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
      .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
      .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      logic        chk_data;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          en_cycles;
   } apb_t;

   rsp_t b_q[$];
   rsp_t r_q[$];
   apb_t apb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   int          apb_delay = 0;
   logic [31:0] apb_rdata = 32'h0;
   logic        apb_err   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // APB slave model and APB-side checker in one process so pready and the check agree.
   int   acc_cnt = 0;
   logic psel_prev = 1'b0;
   always @(negedge clk) begin
      if (psel && penable) begin
         pready = (acc_cnt >= apb_delay);
         acc_cnt++;
      end else begin
         pready  = 1'b0;
         acc_cnt = 0;
      end
      prdata  = pready ? apb_rdata : 32'h0;
      pslverr = pready && apb_err;
      if (psel) begin
         if (apb_q.size() == 0) begin
            chk("apb_unexpected_psel", 32'(psel), 32'h0);
         end else begin
            if (!psel_prev) chk("setup_penable_low", 32'(penable), 32'h0);
            chk("paddr", paddr, apb_q[0].addr);
            chk("pwrite", 32'(pwrite), 32'(apb_q[0].wr));
            chk("pstrb", 32'(pstrb), 32'(apb_q[0].strb));
            chk("pprot", 32'(pprot), 32'(apb_q[0].prot));
            if (apb_q[0].wr) chk("pwdata", pwdata, apb_q[0].wdata);
            if (penable && pready) begin
               chk("penable_cycles", 32'(acc_cnt), 32'(apb_q[0].en_cycles));
               void'(apb_q.pop_front());
            end
         end
      end
      psel_prev = psel;
   end

   // AXI response checker.
   int   aw_hs_cyc = 0;
   int   ar_hs_cyc = 0;
   logic b_prev = 1'b0;
   logic r_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         b_prev = 1'b0;
         r_prev = 1'b0;
      end else begin
         if (axil.aw_ready || axil.w_ready)
            chk("aw_w_ready_together", 32'(axil.aw_ready), 32'(axil.w_ready));
         if (axil.aw_valid && axil.aw_ready) aw_hs_cyc = cyc;
         if (axil.ar_valid && axil.ar_ready) ar_hs_cyc = cyc;
         if (axil.b_valid) begin
            if (b_q.size() == 0) begin
               chk("b_unexpected", 32'(axil.b_valid), 32'h0);
            end else begin
               if (!b_prev) chk("b_latency", 32'(cyc - aw_hs_cyc), 32'(b_q[0].lat));
               if (axil.b_ready) begin
                  chk("b_resp", 32'(axil.b_resp), 32'(b_q[0].resp));
                  void'(b_q.pop_front());
               end
            end
         end
         if (axil.r_valid) begin
            if (r_q.size() == 0) begin
               chk("r_unexpected", 32'(axil.r_valid), 32'h0);
            end else begin
               if (!r_prev) chk("r_latency", 32'(cyc - ar_hs_cyc), 32'(r_q[0].lat));
               if (axil.r_ready) begin
                  chk("r_resp", 32'(axil.r_resp), 32'(r_q[0].resp));
                  if (r_q[0].chk_data) chk("r_data", axil.r_data, r_q[0].data);
                  void'(r_q.pop_front());
               end
            end
         end
         b_prev = axil.b_valid;
         r_prev = axil.r_valid;
      end
   end

   task automatic exp_apb(input logic [31:0] a, input logic wr, input logic [31:0] d,
                          input logic [3:0] s, input logic [2:0] p, input int n);
      apb_t t;
      t.addr = a; t.wr = wr; t.wdata = d; t.strb = s; t.prot = p; t.en_cycles = n;
      apb_q.push_back(t);
   endtask

   task automatic exp_b(input logic [1:0] rs, input int lat);
      rsp_t t;
      t.resp = rs; t.data = 32'h0; t.chk_data = 1'b0; t.lat = lat;
      b_q.push_back(t);
   endtask

   task automatic exp_r(input logic [1:0] rs, input logic [31:0] d, input logic cd, input int lat);
      rsp_t t;
      t.resp = rs; t.data = d; t.chk_data = cd; t.lat = lat;
      r_q.push_back(t);
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p);
      logic ok = 1'b0;
      axil.aw_addr = a; axil.aw_prot = p; axil.w_data = d; axil.w_strb = s;
      axil.aw_valid = 1'b1; axil.w_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = axil.aw_ready && axil.w_ready;
      end
      chk("aw_handshake", 32'(ok), 32'h1);
      @(posedge clk); #1;
      axil.aw_valid = 1'b0; axil.w_valid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [2:0] p);
      logic ok = 1'b0;
      axil.ar_addr = a; axil.ar_prot = p; axil.ar_valid = 1'b1;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = axil.ar_ready;
      end
      chk("ar_handshake", 32'(ok), 32'h1);
      @(posedge clk); #1;
      axil.ar_valid = 1'b0;
   endtask

   task automatic drain();
      logic done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (b_q.size() == 0) && (r_q.size() == 0);
      end
      chk("responses_drained", 32'(done), 32'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      axil.aw_valid = 1'b0; axil.w_valid = 1'b0; axil.ar_valid = 1'b0;
      axil.aw_addr = 32'h0; axil.aw_prot = 3'h0; axil.w_data = 32'h0; axil.w_strb = 4'h0;
      axil.ar_addr = 32'h0; axil.ar_prot = 3'h0;
      axil.b_ready = 1'b1; axil.r_ready = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_aw_ready", 32'(axil.aw_ready), 32'h0);
      chk("rst_w_ready", 32'(axil.w_ready), 32'h0);
      chk("rst_ar_ready", 32'(axil.ar_ready), 32'h0);
      chk("rst_b_valid", 32'(axil.b_valid), 32'h0);
      chk("rst_r_valid", 32'(axil.r_valid), 32'h0);
      chk("rst_psel", 32'(psel), 32'h0);
      chk("rst_penable", 32'(penable), 32'h0);
      chk("rst_resp", 32'({axil.b_resp, axil.r_resp}), 32'h0);
      chk("rst_r_data", axil.r_data, 32'h0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_pstrb_pprot", 32'({pstrb, pprot}), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Simultaneous write and read right after reset: write wins, read follows.
      apb_delay = 0; apb_rdata = 32'h0BAD_CAFE; apb_err = 1'b0;
      exp_apb(32'h0000_0020, 1'b1, 32'hCAFE_F00D, 4'b0011, 3'b000, 1);
      exp_apb(32'h0000_0024, 1'b0, 32'h0, 4'b0000, 3'b011, 1);
      exp_b(RESP_OKAY, 3);
      exp_r(RESP_OKAY, 32'h0BAD_CAFE, 1'b1, 3);
      fork
         axi_write(32'h0000_0020, 32'hCAFE_F00D, 4'b0011, 3'b000);
         axi_read(32'h0000_0024, 3'b011);
      join
      drain();

      // Zero-wait write.
      exp_apb(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 1);
      exp_b(RESP_OKAY, 3);
      axi_write(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
      drain();

      // Read with pready delayed 5 cycles.
      apb_delay = 5; apb_rdata = 32'h1234_5678;
      exp_apb(32'h0000_0004, 1'b0, 32'h0, 4'h0, 3'b001, 6);
      exp_r(RESP_OKAY, 32'h1234_5678, 1'b1, 8);
      axi_read(32'h0000_0004, 3'b001);
      drain();

      // Read response held while r_ready is low.
      apb_delay = 2; apb_rdata = 32'hA5A5_0F0F;
      exp_apb(32'h0000_0008, 1'b0, 32'h0, 4'h0, 3'b000, 3);
      exp_r(RESP_OKAY, 32'hA5A5_0F0F, 1'b1, 5);
      axil.r_ready = 1'b0;
      axi_read(32'h0000_0008, 3'b000);
      repeat (8) @(posedge clk);
      #1 axil.r_ready = 1'b1;
      drain();

      // Window boundaries and out-of-window decode errors.
      apb_delay = 0;
      exp_apb(32'h0000_FFFC, 1'b1, 32'h0F0F_1234, 4'b1100, 3'b001, 1);
      exp_b(RESP_OKAY, 3);
      axi_write(32'h0000_FFFC, 32'h0F0F_1234, 4'b1100, 3'b001);
      drain();
      exp_b(RESP_DECERR, 1);
      axi_write(32'h0001_0000, 32'h1111_2222, 4'hF, 3'b000);
      drain();
      exp_r(RESP_DECERR, 32'h0, 1'b1, 1);
      axi_read(32'h0002_0000, 3'b000);
      drain();

      // Slave errors on read and write.
      apb_delay = 1; apb_err = 1'b1; apb_rdata = 32'h5555_AAAA;
      exp_apb(32'h0000_0030, 1'b0, 32'h0, 4'h0, 3'b000, 2);
      exp_r(RESP_SLVERR, 32'h0, 1'b0, 4);
      axi_read(32'h0000_0030, 3'b000);
      drain();
      apb_delay = 0;
      exp_apb(32'h0000_0060, 1'b1, 32'h0000_0000, 4'b1000, 3'b100, 1);
      exp_b(RESP_SLVERR, 3);
      axi_write(32'h0000_0060, 32'h0000_0000, 4'b1000, 3'b100);
      drain();
      apb_err = 1'b0;

`ifdef AXIL_APB_TIMEOUT_EN
      // Stuck slave: SLVERR after 8 ACCESS cycles.
      apb_delay = 100000;
      exp_apb(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000, 0);
      exp_r(RESP_SLVERR, 32'h0, 1'b1, 10);
      axi_read(32'h0000_0040, 3'b000);
      drain();
      apb_q.delete();
`endif

      // Reset during ACCESS aborts the write silently and restores write-first arbitration.
      apb_delay = 100000;
      exp_apb(32'h0000_0050, 1'b1, 32'h1122_3344, 4'hF, 3'b000, 0);
      axi_write(32'h0000_0050, 32'h1122_3344, 4'hF, 3'b000);
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = penable;
         end
         chk("reached_access", 32'(seen), 32'h1);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      apb_q.delete();
      @(negedge clk);
      chk("abort_psel", 32'(psel), 32'h0);
      chk("abort_penable", 32'(penable), 32'h0);
      chk("abort_b_valid", 32'(axil.b_valid), 32'h0);
      repeat (4) @(posedge clk);
      #1;
      apb_delay = 0; apb_rdata = 32'h7777_8888;
      exp_apb(32'h0000_0070, 1'b1, 32'h9999_AAAA, 4'b0101, 3'b000, 1);
      exp_apb(32'h0000_0074, 1'b0, 32'h0, 4'h0, 3'b000, 1);
      exp_b(RESP_OKAY, 3);
      exp_r(RESP_OKAY, 32'h7777_8888, 1'b1, 3);
      fork
         axi_write(32'h0000_0070, 32'h9999_AAAA, 4'b0101, 3'b000);
         axi_read(32'h0000_0074, 3'b000);
      join
      drain();

      chk("apb_queue_empty", 32'(apb_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/axil_apb_bridge.md
AXIL_APB_BRIDGE -- requirements
Module: axil_apb_bridge

Interface
REQ-001 SHALL have parameter AXI_LITE_AW, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter AXI_LITE_DW, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter APB_AW, default 32, APB address width; must be <= AXI_LITE_AW.
REQ-004 SHALL have parameter PERIPH_BA, default 32'h0000_0000, base of the decoded window.
REQ-005 SHALL have parameter PERIPH_SIZE, default 32'h0001_0000, window size in bytes; must be a power of two.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum cycles spent in ACCESS.
REQ-007 SHALL have port clk_i  input  1  single clock; all logic is clocked on the rising edge.
REQ-008 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port axil_slave  AXI_LITE.Slave modport  AW/DW  AXI-Lite slave port (aw, w, b, ar, r channels).
REQ-010 SHALL have port paddr_o  output  APB_AW  APB address, equal to the AXI address minus PERIPH_BA.
REQ-011 SHALL have port psel_o  output  1  APB select.
REQ-012 SHALL have port penable_o  output  1  APB enable.
REQ-013 SHALL have port pwrite_o  output  1  APB write (1) or read (0).
REQ-014 SHALL have port pwdata_o  output  32  APB write data.
REQ-015 SHALL have port pstrb_o  output  4  APB byte strobes, equal to w_strb on writes and 0 on reads.
REQ-016 SHALL have port pprot_o  output  3  APB protection, copied from aw_prot or ar_prot.
REQ-017 SHALL have port prdata_i  input  32  APB read data.
REQ-018 SHALL have port pready_i  input  1  APB ready.
REQ-019 SHALL have port pslverr_i  input  1  APB slave error.

Function
REQ-020 SHALL implement an FSM with states IDLE, SETUP, ACCESS, RESP and SHALL allow only one outstanding transaction.
REQ-021 IDLE: a write SHALL be accepted only when aw_valid and w_valid are both high; aw_ready and w_ready SHALL pulse together for one cycle.
REQ-022 IDLE: a read SHALL be accepted when ar_valid is high; ar_ready SHALL pulse for one cycle.
REQ-023 When read and write requests are pending in the same cycle, the bridge SHALL alternate between them, granting the type opposite to the last grant; the first grant after reset is the write.
REQ-024 On acceptance of an in-window address, the FSM SHALL go to SETUP (psel=1, penable=0) for exactly one cycle, then to ACCESS (psel=1, penable=1).
REQ-025 ACCESS SHALL hold until pready_i is high; on that edge it SHALL capture prdata_i and pslverr_i, deassert psel and penable, and go to RESP.
REQ-026 RESP SHALL assert b_valid (write) or r_valid (read) and hold it, with data stable, until b_ready or r_ready; the FSM then returns to IDLE.
REQ-027 Response codes SHALL be: OKAY 2'b00; SLVERR 2'b10 when pslverr is high; DECERR 2'b11 for out-of-window addresses.
REQ-028 Addresses outside [PERIPH_BA, PERIPH_BA+PERIPH_SIZE) SHALL go directly to RESP with DECERR and no APB cycle; r_data SHALL be 0.
REQ-029 Latency SHALL be a minimum of 3 cycles from the accept edge to b_valid/r_valid (SETUP, ACCESS with pready, RESP) and exactly 1 cycle for DECERR.
REQ-030 paddr, pwrite, pwdata, pstrb and pprot SHALL be registered at accept and remain stable through SETUP and ACCESS.

Reset
REQ-031 While rst_i is high at a clock edge, the FSM SHALL enter IDLE and all ready, valid, psel and penable outputs SHALL be 0.
REQ-032 While rst_i is high at a clock edge, resp, r_data, paddr, pwdata, pstrb and pprot SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL abort it silently: no response is issued, the arbitration flag is restored to write-first, and the timeout counter is cleared.

Configuration
REQ-034 With AXIL_APB_TIMEOUT_EN defined, a counter SHALL run in ACCESS; if pready_i is still low after TIMEOUT_CYCLES cycles, the bridge SHALL drop psel/penable and respond SLVERR (r_data=0).
REQ-035 Without AXIL_APB_TIMEOUT_EN, ACCESS SHALL wait indefinitely for pready_i, and no counter logic SHALL be present.

Structure
REQ-036 A shared package axil_apb_pkg SHALL hold the FSM state enum and the RESP_OKAY, RESP_SLVERR and RESP_DECERR constants.
REQ-037 The block SHALL be a single module; no sub-module is needed (the arbiter and timeout logic are inline).

Verification
REQ-038 Write 0x0000_0010 with data 0xDEAD_BEEF, strb 0xF, pready high immediately -> SETUP then ACCESS, pwdata 0xDEAD_BEEF, b_resp 2'b00 three cycles after accept.
REQ-039 Read 0x0000_0004 with prdata 0x1234_5678 and pready delayed 5 cycles -> penable held for 6 cycles, r_data 0x1234_5678, r_resp 2'b00.
REQ-040 aw, w and ar valid in the same cycle after reset -> write granted first, read second, each with its own response.
REQ-041 Read 0x0002_0000 (out of window) -> no psel, r_resp 2'b11, r_data 0 one cycle after accept.
REQ-042 Read with pslverr high -> r_resp 2'b10; with AXIL_APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready stuck low -> r_resp 2'b10 after 8 ACCESS cycles.
REQ-043 rst_i pulsed during ACCESS -> psel/penable 0 next cycle, no b_valid issued, next write completes normally.
